// File: rtl/burst_fill_responder.sv
// burst_fill_responder
//   Responder side of the cache <-> SDRAM burst link. A line read fetches
//   LINE_WORDS words from a 32-bit req/ack backing memory in wrap order,
//   starting at the critical word. It then streams them back as a gapless
//   run of halfwords, high half first. A word write collects two halfwords
//   from the cache and issues a single 32-bit memory write.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-low reset
//   req, rw, addr    cache request (level), 1=line read / 0=word write, byte addr
//   wdata            write halfword (high half at accept, low half after fill)
//   rdata, fill      fill halfword stream; fill pulses on first halfword / write-high taken
//   busy             responder not idle
//   mem_addr/req/wr/wdata, mem_rdata/ack   backing-memory handshake
module burst_fill_responder #(
  parameter int MIN_LATENCY = 4,
  parameter int LINE_WORDS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        fill,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int          IDX_W   = $clog2(LINE_WORDS);
  localparam logic [3:0]  LAT_THR = 4'(MIN_LATENCY - 1);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(LINE_WORDS - 1);
  localparam logic [IDX_W:0]   S_LAST = (IDX_W+1)'(2*LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_HOLD, S_STREAM, S_WHI, S_WLO, S_WMEM, S_REL
  } state_t;

  state_t                 state, state_n;
  logic [31:IDX_W+2]      line_addr;
  logic [IDX_W-1:0]       widx;
  logic [IDX_W-1:0]       fetch_k;
  logic [15:0]            whi;
  logic [3:0]             lat_cnt;
  logic [LINE_WORDS-1:0]  bvalid;
  logic [IDX_W:0]         s_cnt;
  logic [31:0]            buf_q [LINE_WORDS];
  logic                   lat_ok;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];
  assign lat_ok          = (lat_cnt >= LAT_THR);

  // Next state and all handshake/stream outputs are decoded from the state,
  // so a reset edge clears them in the very next cycle.
  always_comb begin
    state_n = state;
    fill    = 1'b0;
    busy    = (state != S_IDLE);
    mem_req = 1'b0;
    mem_wr  = 1'b0;
    rdata   = '0;
    case (state)
      S_IDLE:   if (req) state_n = rw ? S_FETCH : S_WHI;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack && fetch_k == K_LAST) state_n = S_HOLD;
      end
      // Stream only once the emulated latency has elapsed and every word is in.
      S_HOLD:   if (lat_ok && (&bvalid)) state_n = S_STREAM;
      S_STREAM: begin
        fill  = (s_cnt == '0);
        rdata = s_cnt[0] ? buf_q[s_cnt[IDX_W:1]][15:0] : buf_q[s_cnt[IDX_W:1]][31:16];
        if (s_cnt == S_LAST) state_n = S_REL;
      end
      S_WHI: begin
        fill    = 1'b1;
        state_n = S_WLO;
      end
      S_WLO:    state_n = S_WMEM;
      S_WMEM: begin
        mem_req = 1'b1;
        mem_wr  = 1'b1;
        if (mem_ack) state_n = S_REL;
      end
      // Hold here until the cache lets go of req so it is not re-accepted.
      S_REL:    if (!req) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      line_addr <= '0;
      widx      <= '0;
      fetch_k   <= '0;
      whi       <= '0;
      lat_cnt   <= '0;
      bvalid    <= '0;
      s_cnt     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      if (lat_cnt != 4'hF) lat_cnt <= lat_cnt + 4'd1;
      case (state)
        S_IDLE: if (req) begin
          line_addr <= addr[31:IDX_W+2];
          widx      <= addr[IDX_W+1:2];
          lat_cnt   <= '0;
          fetch_k   <= '0;
          bvalid    <= '0;
          s_cnt     <= '0;
          if (rw) mem_addr <= {addr[31:2], 2'b00};
          else    whi      <= wdata;
        end
        S_FETCH: if (mem_ack) begin
          bvalid[fetch_k] <= 1'b1;
          fetch_k         <= fetch_k + 1'b1;
          // Step to the next word of the line, wrapping within it.
          mem_addr        <= {line_addr, IDX_W'(widx + fetch_k + 1'b1), 2'b00};
        end
        S_STREAM: s_cnt <= s_cnt + 1'b1;
        S_WLO: begin
          mem_addr  <= {line_addr, widx, 2'b00};
          mem_wdata <= {whi, wdata};
        end
        default: ;
      endcase
    end
  end

  // Line buffer holds data only; validity is tracked by bvalid.
  always_ff @(posedge clk) begin
    if (state == S_FETCH && mem_ack) buf_q[fetch_k] <= mem_rdata;
  end
endmodule

// File: tb/tb_burst_fill_responder.sv
module tb_burst_fill_responder;
  localparam int ML = 4;

  logic        clk = 1'b0, reset = 1'b0;
  logic        req, rw;
  logic [31:0] addr;
  logic [15:0] wdata, rdata;
  logic        fill, busy, mem_req, mem_wr, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        b_req, b_rw;
  logic [31:0] b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic        b_fill, b_busy, b_mem_req, b_mem_wr, b_mem_ack;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  always #5 clk = ~clk;

  burst_fill_responder #(.MIN_LATENCY(ML), .LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .fill(fill), .busy(busy), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  burst_fill_responder #(.MIN_LATENCY(15), .LINE_WORDS(4)) dut_b (
    .clk(clk), .reset(reset), .req(b_req), .rw(b_rw), .addr(b_addr), .wdata(b_wdata),
    .rdata(b_rdata), .fill(b_fill), .busy(b_busy), .mem_addr(b_mem_addr), .mem_req(b_mem_req),
    .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack));

  // Zero-wait memory for the long-latency instance: word content derived from address.
  assign b_mem_ack   = b_mem_req;
  assign b_mem_rdata = {16'hB0B0, b_mem_addr[15:0]};

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Backing memory for the main instance, configurable ack delay.
  logic [31:0] mem [4096];
  logic [31:0] shd [4096];
  int mem_lat = 0;
  int mwait = 0;
  always @(posedge clk) begin
    if (!reset) begin
      mem_ack <= 1'b0;
      mwait   <= 0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
      mwait   <= 0;
    end else if (mem_req) begin
      if (mwait >= mem_lat) begin
        mem_ack <= 1'b1;
        if (mem_wr) mem[mem_addr[13:2]] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr[13:2]];
      end else mwait <= mwait + 1;
    end
  end

  // Reference transaction: expected fetch addresses and halfword stream come
  // from the shadow memory at issue time.
  typedef struct packed {
    logic              rw;
    logic [31:0]       a;
    logic [15:0]       hi;
    logic [15:0]       lo;
    logic [31:0]       acc;
    logic [7:0][15:0]  hw;
    logic [3:0][31:0]  ea;
  } tx_t;
  tx_t txq[$];

  function automatic tx_t make_tx(input logic t_rw, input logic [31:0] a,
                                  input logic [15:0] hi, input logic [15:0] lo);
    tx_t t;
    logic [31:0] wa;
    logic [31:0] w;
    t = '0;
    t.rw = t_rw; t.a = a; t.hi = hi; t.lo = lo;
    for (int k = 0; k < 4; k++) begin
      wa = (a & 32'hFFFF_FFF0) + 32'(((a[3:2] + k) % 4) * 4);
      w  = shd[wa[13:2]];
      t.ea[k] = wa;
      t.hw[2*k]   = w[31:16];
      t.hw[2*k+1] = w[15:0];
    end
    return t;
  endfunction

  // Single compare process for the main instance.
  int s_pos = -1;
  bit wfill = 0;
  logic [31:0] got_addr[$];
  logic prev_req = 0, prev_ack = 0;
  logic [31:0] prev_addr = 0;
  always @(negedge clk) begin
    if (!reset) begin
      txq.delete(); got_addr.delete();
      s_pos = -1; wfill = 0; prev_req = 0; prev_ack = 0;
    end else begin
      if (prev_req && !prev_ack) begin
        chk("mem_req_held", 32'(mem_req), 1);
        if (mem_req) chk("mem_addr_stable", mem_addr, prev_addr);
      end
      if (mem_req && mem_ack && !mem_wr) got_addr.push_back(mem_addr);
      if (mem_req && mem_ack && mem_wr) begin
        chk("wr_expected", 32'(txq.size() > 0 && !txq[0].rw && wfill), 1);
        if (txq.size() > 0 && !txq[0].rw) begin
          chk("wr_addr", mem_addr, {txq[0].a[31:2], 2'b00});
          chk("wr_data", mem_wdata, {txq[0].hi, txq[0].lo});
          chk("wr_busy", 32'(busy), 1);
          void'(txq.pop_front());
          wfill = 0;
        end
      end
      if (fill && s_pos < 0) begin
        chk("fill_has_tx", 32'(txq.size() > 0), 1);
        if (txq.size() > 0) begin
          if (txq[0].rw) begin
            chk("fill_lat_min", 32'((cyc - int'(txq[0].acc)) >= ML), 1);
            chk("fetch_count", 32'(got_addr.size()), 4);
            for (int k = 0; k < 4 && k < got_addr.size(); k++)
              chk("fetch_addr", got_addr[k], txq[0].ea[k]);
            got_addr.delete();
            s_pos = 0;
          end else begin
            chk("single_wfill", 32'(wfill), 0);
            wfill = 1;
          end
        end
      end
      if (s_pos >= 0) begin
        if (s_pos < 8) begin
          chk("stream_rdata", 32'(rdata), 32'(txq[0].hw[s_pos]));
          chk("stream_fill", 32'(fill), 32'(s_pos == 0));
          s_pos++;
        end else begin
          chk("post_rdata", 32'(rdata), 0);
          chk("post_fill", 32'(fill), 0);
          void'(txq.pop_front());
          s_pos = -1;
        end
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin @(posedge clk); #1; n++; end
    if (busy) chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic do_tx(input logic t_rw, input logic [31:0] a, input logic [15:0] hi,
                       input logic [15:0] lo, output tx_t t, output int lat);
    int n;
    wait_idle();
    t = make_tx(t_rw, a, hi, lo);
    t.acc = 32'(cyc + 1);
    if (!t_rw) shd[a[13:2]] = {hi, lo};
    txq.push_back(t);
    req = 1'b1; rw = t_rw; addr = a; wdata = hi;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!fill && n < 400);
    chk("fill_seen", 32'(fill), 1);
    lat = cyc - int'(t.acc);
    @(posedge clk); #1;
    req = 1'b0;
    wdata = t_rw ? 16'($urandom) : lo;
    rw = 1'($urandom);
    addr = $urandom;
    wait_idle();
  endtask

  initial begin
    tx_t t;
    int lat, n, acc;
    logic [15:0] exp1 [8];
    logic [15:0] bexp [8];
    logic [31:0] a;
    exp1 = '{16'hA0A0, 16'h0002, 16'hA0A0, 16'h0003, 16'hA0A0, 16'h0000, 16'hA0A0, 16'h0001};
    bexp = '{16'hB0B0, 16'h0004, 16'hB0B0, 16'h0008, 16'hB0B0, 16'h000C, 16'hB0B0, 16'h0000};
    for (int i = 0; i < 4096; i++) begin
      mem[i] <= 32'hA0A0_0000 + 32'(i) - 32'h400;
      shd[i]  = 32'hA0A0_0000 + 32'(i) - 32'h400;
    end
    req = 0; rw = 0; addr = 0; wdata = 0;
    b_req = 0; b_rw = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // MIN_LATENCY=15, zero-wait memory: fill lands exactly 15 cycles after accept.
    b_req = 1; b_rw = 1; b_addr = 32'h0000_0004; acc = cyc + 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b_fill && n < 100);
    chk("b_fill_lat", 32'(cyc - acc), 15);
    for (int s = 0; s < 8; s++) begin
      chk("b_rdata", 32'(b_rdata), 32'(bexp[s]));
      chk("b_fill", 32'(b_fill), 32'(s == 0));
      @(posedge clk); #1;
      if (s == 0) b_req = 0;
    end
    chk("b_post_rdata", 32'(b_rdata), 0);

    // Fast memory, critical word first at 0x1008.
    mem_lat = 0;
    do_tx(1'b1, 32'h0000_1008, 16'h0, 16'h0, t, lat);
    for (int s = 0; s < 8; s++) chk("model_stream", 32'(t.hw[s]), 32'(exp1[s]));
    chk("model_ea0", t.ea[0], 32'h1008);
    chk("model_ea2", t.ea[2], 32'h1000);
    chk("fast_lat_lt14", 32'(lat < 14), 1);

    // Slow memory: every word costs ~10 cycles before fill is allowed.
    mem_lat = 10;
    do_tx(1'b1, 32'h0000_1008, 16'h0, 16'h0, t, lat);
    chk("slow_lat_ge40", 32'(lat >= 40), 1);
    mem_lat = 0;

    // Word write.
    do_tx(1'b0, 32'h0000_2004, 16'hDEAD, 16'hBEEF, t, lat);
    chk("wr_mem_word", mem[12'h801], 32'hDEADBEEF);

    // Reset in the middle of a stream, then a fresh read.
    wait_idle();
    t = make_tx(1'b1, 32'h0000_1004, 16'h0, 16'h0);
    t.acc = 32'(cyc + 1);
    txq.push_back(t);
    req = 1; rw = 1; addr = 32'h0000_1004;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!fill && n < 400);
    chk("rst_fill_seen", 32'(fill), 1);
    @(posedge clk); #1; req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 0;
    @(posedge clk); #1;
    chk("mid_rst_fill", 32'(fill), 0);
    chk("mid_rst_rdata", 32'(rdata), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_mem_req", 32'(mem_req), 0);
    reset = 1;
    @(posedge clk); #1;
    do_tx(1'b1, 32'h0000_3000, 16'h0, 16'h0, t, lat);
    chk("model_3000", 32'(t.hw[1]), 32'h0800);

    // Back-to-back write then read with one idle cycle between.
    do_tx(1'b0, 32'h0000_1004, 16'h1234, 16'h5678, t, lat);
    @(posedge clk); #1;
    do_tx(1'b1, 32'h0000_1000, 16'h0, 16'h0, t, lat);
    chk("b2b_model_hi", 32'(t.hw[2]), 32'h1234);
    chk("b2b_model_lo", 32'(t.hw[3]), 32'h5678);

    // Randomized mix over a few lines.
    for (int i = 0; i < 30; i++) begin
      mem_lat = $urandom_range(0, 3);
      a = ($urandom() & 32'hFFFF_C000) | (32'h1000 + (32'($urandom_range(0, 31)) << 2))
          | 32'($urandom_range(0, 3));
      do_tx(1'($urandom_range(0, 1)), a, 16'($urandom), 16'($urandom), t, lat);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/burst_fill_responder.md
Name: burst_fill_responder

Overview:
- Responder end of the cache-to-SDRAM burst interface. It accepts cacheline read requests and single-word write requests from a direct-mapped cache and serves them over the 16-bit burst data path.
- Fills are returned critical-word-first, wrapping within the line, as an 8-halfword gapless stream; each word is sent high half first.
- Backing store is a 32-bit word memory with a req/ack handshake. Used as an on-chip memory front-end and as the bench responder for cache verification.

Parameters:
- MIN_LATENCY, 4: minimum cycles from request acceptance to the first fill pulse; emulates CAS/row latency. Legal range 2..15.
- LINE_WORDS, 4: 32-bit words per cacheline. Fixed at 4; 2-bit word index.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- req  in  1  request from cache, level
- rw  in  1  1 = line read (fill), 0 = word write
- addr  in  32  request address; bits [1:0] ignored
- wdata  in  16  write halfword from cache
- rdata  out  16  fill halfword to cache
- fill  out  1  single-cycle pulse: first fill halfword valid (read), or write-high-half taken (write)
- busy  out  1  high whenever state is not IDLE
- mem_addr  out  32  word address to backing memory, {line[31:4], idx[1:0], 2'b00}
- mem_req  out  1  memory request, held until mem_ack
- mem_wr  out  1  1 = write, valid with mem_req
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe

Behaviour:
- Reset (reset==0 at an edge), from any state including mid-fetch or mid-stream:
  - state=IDLE.
  - rdata, fill, busy, mem_req, mem_wr = 0; mem_addr and mem_wdata = 0.
  - Latency counter and buffer-valid bits cleared.
  - A mem_ack arriving after reset is ignored. mem_ack is only honoured in FETCH and WMEM.
- IDLE: on req==1, latch addr into line_addr and set widx=addr[3:2].
  - rw=1: go to FETCH. Latency counter cleared in the acceptance cycle.
  - rw=0: latch wdata into whi, go to WHI.
- FETCH: issue 4 reads in wrap order widx, widx+1, widx+2, widx+3 (mod 4).
  - mem_req is held with a constant mem_addr until mem_ack.
  - On mem_ack, store mem_rdata in buf[k] (k = 0..3, issue order). The next mem_req is asserted the following cycle.
  - After the 4th ack, go to HOLD.
- HOLD: wait until latency counter >= MIN_LATENCY-1, then go to STREAM. The counter saturates at 15.
- STREAM: 8 consecutive cycles s=0..7, no gaps.
  - rdata = s even ? buf[s/2][31:16] : buf[s/2][15:0].
  - fill=1 only at s=0.
  - After s=7: rdata=0, go to RELEASE.
- Net effect: fill rises no earlier than MIN_LATENCY cycles after acceptance, and only once all 4 words are buffered.
- WHI: fill=1 for one cycle.
- WLO: in the cycle after fill, sample wdata as the low half. Drive mem_wdata={whi, wdata} and mem_addr={line_addr[31:4], widx, 2'b00}. Go to WMEM.
- WMEM: assert mem_req=1 and mem_wr=1 until mem_ack, then go to RELEASE.
- RELEASE: wait for req==0, then go to IDLE. This prevents re-accepting a request that is still held. If req is already low, exit takes one cycle.
- Requestor contract:
  - Drop req in the cycle after seeing fill.
  - For writes, present the low half on the cycle after fill.
  - rw and addr must be stable while req is high until fill.
  - Violations: the request stays latched and the responder completes with the latched values.
- rw changing while in IDLE with req low: no effect.
- Simultaneous reset and mem_ack: reset wins.

Test Plan:
- Fill, fast memory. Memory word at byte address 0x1000+4i = 0xA0A0_0000+i; mem_ack in the cycle after each mem_req rises. Read req at addr 0x1008, MIN_LATENCY=4.
  -> mem_addr sequence 0x1008, 0x100C, 0x1000, 0x1004.
  -> fill pulses once, fewer than 14 cycles after acceptance.
  -> rdata stream: A0A0, 0002, A0A0, 0003, A0A0, 0000, A0A0, 0001.
- Fill, slow memory. mem_ack 10 cycles after each mem_req.
  -> fill occurs only after the 4th ack.
  -> stream remains 8 gapless halfwords.
  -> mem_req never drops before its ack.
- Write. req, rw=0, addr 0x2004, wdata 0xDEAD; cache drives 0xBEEF the cycle after fill.
  -> mem_req=1, mem_wr=1, mem_addr=0x2004, mem_wdata=0xDEADBEEF.
  -> busy stays high until mem_ack.
  -> exactly one fill pulse.
- Reset mid-stream. Assert reset==0 at stream s=3.
  -> next cycle: fill=0, rdata=0, busy=0, mem_req=0.
  -> a new read to 0x3000 after reset returns the correct fresh data.
- Back-to-back. Cache issues a write then a read with one idle cycle between.
  -> the second request is accepted only after RELEASE.
  -> no duplicate fill.
  -> read data reflects the preceding write.
- MIN_LATENCY=15 with zero-wait memory.
  -> fill exactly 15 cycles after the acceptance edge.
